// File: rtl/operand_read_stage_if.sv
// ----------------------------------------------------------------------------
// operand_read_stage_if
//   Groups every non-clock, non-reset signal of operand_read_stage.
//   The slave modport is the stage's view. The master modport is the view of
//   the surrounding issue queue, register file, result buses and execute unit.
//   Signal names keep the pipeline's IN_/OUT_ naming. The parameters must
//   match the ones given to operand_read_stage.
//
//   Issue side   : IN_valid, IN_sqN, IN_tagA/B/Dst, IN_imm, IN_immB,
//                  IN_opcode, IN_fu in; OUT_stall out
//   RF side      : OUT_rfEn, OUT_rfAddrA/B out; IN_rfDataA/B in (one cycle later)
//   Result buses : IN_resValid, IN_resTag, IN_resData in
//   Flush        : IN_branchTaken, IN_branchSqN in
//   Execute side : IN_stall in; OUT_valid, OUT_sqN, OUT_tagDst, OUT_imm,
//                  OUT_opcode, OUT_fu, OUT_srcA, OUT_srcB out
// ----------------------------------------------------------------------------
interface operand_read_stage_if #(
   parameter int XLEN             = 32,
   parameter int TAG_BITS         = 7,
   parameter int SQN_BITS         = 7,
   parameter int RESULT_BUS_COUNT = 4,
   parameter int IMM_BITS         = 32,
   parameter int OPC_BITS         = 6,
   parameter int FU_BITS          = 4
);
   logic                               IN_valid;
   logic [SQN_BITS-1:0]                IN_sqN;
   logic [TAG_BITS-1:0]                IN_tagA;
   logic [TAG_BITS-1:0]                IN_tagB;
   logic [TAG_BITS-1:0]                IN_tagDst;
   logic [IMM_BITS-1:0]                IN_imm;
   logic                               IN_immB;
   logic [OPC_BITS-1:0]                IN_opcode;
   logic [FU_BITS-1:0]                 IN_fu;
   logic                               OUT_stall;

   logic                               OUT_rfEn;
   logic [TAG_BITS-2:0]                OUT_rfAddrA;
   logic [TAG_BITS-2:0]                OUT_rfAddrB;
   logic [XLEN-1:0]                    IN_rfDataA;
   logic [XLEN-1:0]                    IN_rfDataB;

   logic [RESULT_BUS_COUNT-1:0]        IN_resValid;
   logic [RESULT_BUS_COUNT*TAG_BITS-1:0] IN_resTag;
   logic [RESULT_BUS_COUNT*XLEN-1:0]   IN_resData;

   logic                               IN_branchTaken;
   logic [SQN_BITS-1:0]                IN_branchSqN;

   logic                               IN_stall;
   logic                               OUT_valid;
   logic [SQN_BITS-1:0]                OUT_sqN;
   logic [TAG_BITS-1:0]                OUT_tagDst;
   logic [XLEN-1:0]                    OUT_imm;
   logic [OPC_BITS-1:0]                OUT_opcode;
   logic [FU_BITS-1:0]                 OUT_fu;
   logic [XLEN-1:0]                    OUT_srcA;
   logic [XLEN-1:0]                    OUT_srcB;

   modport slave (
      input  IN_valid, IN_sqN, IN_tagA, IN_tagB, IN_tagDst, IN_imm, IN_immB,
             IN_opcode, IN_fu, IN_rfDataA, IN_rfDataB, IN_resValid, IN_resTag,
             IN_resData, IN_branchTaken, IN_branchSqN, IN_stall,
      output OUT_stall, OUT_rfEn, OUT_rfAddrA, OUT_rfAddrB, OUT_valid, OUT_sqN,
             OUT_tagDst, OUT_imm, OUT_opcode, OUT_fu, OUT_srcA, OUT_srcB
   );

   modport master (
      output IN_valid, IN_sqN, IN_tagA, IN_tagB, IN_tagDst, IN_imm, IN_immB,
             IN_opcode, IN_fu, IN_rfDataA, IN_rfDataB, IN_resValid, IN_resTag,
             IN_resData, IN_branchTaken, IN_branchSqN, IN_stall,
      input  OUT_stall, OUT_rfEn, OUT_rfAddrA, OUT_rfAddrB, OUT_valid, OUT_sqN,
             OUT_tagDst, OUT_imm, OUT_opcode, OUT_fu, OUT_srcA, OUT_srcB
   );
endinterface

// File: rtl/operand_read_stage.sv
// ----------------------------------------------------------------------------
// operand_read_stage
//   Register-read stage that sits behind the issue queue. It issues a
//   synchronous RF read when a uop is accepted and holds the uop in slot S1
//   while the data returns. When S1 moves to slot OUT, each operand is
//   resolved from one of three sources: a tag constant, a result-bus bypass,
//   or RF/held data. There are two slots, the stage sustains one uop per
//   cycle, and uops younger than a mispredicted branch are flushed.
//
//   Ports:
//     clk : clock, all state on the rising edge
//     rst : asynchronous active-low reset
//     bus : operand_read_stage_if.slave (issue, RF, result buses, flush, execute)
//
//   Handshakes:
//     The issue side transfers a uop on a cycle with IN_valid && !OUT_stall.
//     A uop younger than a branch flushed in the same cycle is not taken.
//     The execute side takes a uop on a cycle with OUT_valid && !IN_stall.
//     While OUT_valid && IN_stall, every OUT_* signal stays stable.
// ----------------------------------------------------------------------------
module operand_read_stage #(
   parameter int XLEN             = 32,
   parameter int TAG_BITS         = 7,
   parameter int SQN_BITS         = 7,
   parameter int RESULT_BUS_COUNT = 4,
   parameter int IMM_BITS         = 32,
   parameter int OPC_BITS         = 6,
   parameter int FU_BITS          = 4
) (
   input logic                 clk,
   input logic                 rst,
   operand_read_stage_if.slave bus
);

   // x is younger than branch br when (x - br) is strictly positive as a
   // signed SQN_BITS value. This keeps the comparison valid across wrap.
   function automatic logic younger(input logic [SQN_BITS-1:0] x,
                                    input logic [SQN_BITS-1:0] br);
      logic [SQN_BITS-1:0] d;
      d = x - br;
      return !d[SQN_BITS-1] && (d != '0);
   endfunction

   // Priority is: tag constant, then the lowest-index matching result bus,
   // then RF or held data. A bus tag with its MSB set can never equal a
   // register tag, because the constant case has already been taken.
   function automatic logic [XLEN-1:0] resolve(
      input logic [TAG_BITS-1:0]                  tag,
      input logic [RESULT_BUS_COUNT-1:0]          rv,
      input logic [RESULT_BUS_COUNT*TAG_BITS-1:0] rt,
      input logic [RESULT_BUS_COUNT*XLEN-1:0]     rd,
      input logic                                 fresh,
      input logic [XLEN-1:0]                      rf,
      input logic [XLEN-1:0]                      held);
      logic [XLEN-1:0] r;
      logic            hit;
      r   = fresh ? rf : held;
      hit = 1'b0;
      if (tag[TAG_BITS-1]) begin
         r = {{(XLEN-TAG_BITS+1){tag[TAG_BITS-2]}}, tag[TAG_BITS-2:0]};
      end else begin
         for (int i = 0; i < RESULT_BUS_COUNT; i++) begin
            if (!hit && rv[i] && (rt[i*TAG_BITS +: TAG_BITS] == tag)) begin
               r   = rd[i*XLEN +: XLEN];
               hit = 1'b1;
            end
         end
      end
      return r;
   endfunction

   // Immediate widened to XLEN once, at capture.
   logic [XLEN-1:0] imm_ext;
   if (IMM_BITS < XLEN) begin : g_imm_ext
      assign imm_ext = {{(XLEN-IMM_BITS){bus.IN_imm[IMM_BITS-1]}}, bus.IN_imm};
   end else begin : g_imm_full
      assign imm_ext = bus.IN_imm[XLEN-1:0];
   end

   // Slot S1
   logic                s1_valid;
   logic                s1_fresh;   // RF data for this uop is on IN_rfData now
   logic [SQN_BITS-1:0] s1_sqn;
   logic [TAG_BITS-1:0] s1_tag_a;
   logic [TAG_BITS-1:0] s1_tag_b;
   logic [TAG_BITS-1:0] s1_tag_dst;
   logic [XLEN-1:0]     s1_imm;
   logic                s1_imm_b;
   logic [OPC_BITS-1:0] s1_opcode;
   logic [FU_BITS-1:0]  s1_fu;
   logic [XLEN-1:0]     held_a;
   logic [XLEN-1:0]     held_b;

   // Slot OUT
   logic                out_valid;
   logic [SQN_BITS-1:0] out_sqn;
   logic [TAG_BITS-1:0] out_tag_dst;
   logic [XLEN-1:0]     out_imm;
   logic [OPC_BITS-1:0] out_opcode;
   logic [FU_BITS-1:0]  out_fu;
   logic [XLEN-1:0]     out_src_a;
   logic [XLEN-1:0]     out_src_b;

   logic            advance;
   logic            stall_in;
   logic            accept;
   logic            s1_flush;
   logic            s1_live;
   logic            out_flush;
   logic [XLEN-1:0] res_a;
   logic [XLEN-1:0] res_b;

   always_comb begin
      advance   = !out_valid || !bus.IN_stall;
      // The stall ignores flushes. This keeps it off the flush compare path.
      stall_in  = s1_valid && !advance;
      accept    = bus.IN_valid && !stall_in &&
                  !(bus.IN_branchTaken && younger(bus.IN_sqN, bus.IN_branchSqN));
      s1_flush  = bus.IN_branchTaken && younger(s1_sqn, bus.IN_branchSqN);
      s1_live   = s1_valid && !s1_flush;
      out_flush = bus.IN_branchTaken && younger(out_sqn, bus.IN_branchSqN);
      res_a     = resolve(s1_tag_a, bus.IN_resValid, bus.IN_resTag, bus.IN_resData,
                          s1_fresh, bus.IN_rfDataA, held_a);
      res_b     = s1_imm_b ? s1_imm :
                  resolve(s1_tag_b, bus.IN_resValid, bus.IN_resTag, bus.IN_resData,
                          s1_fresh, bus.IN_rfDataB, held_b);
   end

   assign bus.OUT_stall   = stall_in;
   assign bus.OUT_rfEn    = accept;
   assign bus.OUT_rfAddrA = bus.IN_tagA[TAG_BITS-2:0];
   assign bus.OUT_rfAddrB = bus.IN_tagB[TAG_BITS-2:0];

   assign bus.OUT_valid   = out_valid;
   assign bus.OUT_sqN     = out_sqn;
   assign bus.OUT_tagDst  = out_tag_dst;
   assign bus.OUT_imm     = out_imm;
   assign bus.OUT_opcode  = out_opcode;
   assign bus.OUT_fu      = out_fu;
   assign bus.OUT_srcA    = out_src_a;
   assign bus.OUT_srcB    = out_src_b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid    <= 1'b0;
         s1_fresh    <= 1'b0;
         s1_sqn      <= '0;
         s1_tag_a    <= '0;
         s1_tag_b    <= '0;
         s1_tag_dst  <= '0;
         s1_imm      <= '0;
         s1_imm_b    <= 1'b0;
         s1_opcode   <= '0;
         s1_fu       <= '0;
         held_a      <= '0;
         held_b      <= '0;
         out_valid   <= 1'b0;
         out_sqn     <= '0;
         out_tag_dst <= '0;
         out_imm     <= '0;
         out_opcode  <= '0;
         out_fu      <= '0;
         out_src_a   <= '0;
         out_src_b   <= '0;
      end else begin
         // OUT slot
         if (advance) begin
            if (s1_live) begin
               out_valid   <= 1'b1;
               out_sqn     <= s1_sqn;
               out_tag_dst <= s1_tag_dst;
               out_imm     <= s1_imm;
               out_opcode  <= s1_opcode;
               out_fu      <= s1_fu;
               out_src_a   <= res_a;
               out_src_b   <= res_b;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (out_flush) begin
            // A younger uop is killed even while execute is stalling.
            out_valid <= 1'b0;
         end

         // S1 slot
         if (accept) begin
            s1_valid   <= 1'b1;
            s1_fresh   <= 1'b1;
            s1_sqn     <= bus.IN_sqN;
            s1_tag_a   <= bus.IN_tagA;
            s1_tag_b   <= bus.IN_tagB;
            s1_tag_dst <= bus.IN_tagDst;
            s1_imm     <= imm_ext;
            s1_imm_b   <= bus.IN_immB;
            s1_opcode  <= bus.IN_opcode;
            s1_fu      <= bus.IN_fu;
         end else if (s1_valid && (advance || s1_flush)) begin
            s1_valid <= 1'b0;
            s1_fresh <= 1'b0;
         end else if (s1_valid) begin
            // Stalled. The first cycle captures the RF data. Every cycle also
            // folds in bypass hits, so a result broadcast during the stall
            // is not lost.
            held_a   <= res_a;
            held_b   <= res_b;
            s1_fresh <= 1'b0;
         end
      end
   end

endmodule
